// File: rtl/muldiv_ctrl_if.sv
// EX-stage request / read-return bundle for the Hi/Lo multiply sequencer.
// The master side (EX stage) drives requests; the slave side (muldiv_ctrl) answers.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative unsigned MULTU/MADDU sequencer owning the Hi/Lo register, plus MFHI/MFLO reads.
// Optional abort input is compiled in with `define MULDIV_FLUSH_EN.
module muldiv_ctrl #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULDIV_FLUSH_EN
    input  logic             flush,
`endif
    muldiv_ctrl_if.slave     bus,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int N     = WIDTH / STEP_BITS;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 maddu_q, maddu_d;
    logic [2*WIDTH-1:0]   hilo_q, hilo_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic                 flush_w;
    logic                 accept;
    logic [2*WIDTH-1:0]   term [STEP_BITS];
    logic [2*WIDTH-1:0]   addend;

`ifdef MULDIV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // One shifted copy of the multiplicand per multiplier bit retired this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < STEP_BITS; gi++) begin : g_term
            assign term[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
        end
    endgenerate

    always_comb begin
        addend = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            addend = addend + term[i];
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !flush_w;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        maddu_d    = maddu_q;
        hilo_d     = hilo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_op[1]) begin
                        state_d  = RUN;
                        cnt_d    = CNT_W'(N);
                        mcand_d  = {{WIDTH{1'b0}}, bus.req_a};
                        mplier_d = bus.req_b;
                        acc_d    = '0;
                        maddu_d  = bus.req_op[0];
                    end else begin
                        rd_data_d  = bus.req_op[0] ? hilo_q[WIDTH-1:0]
                                                   : hilo_q[2*WIDTH-1:WIDTH];
                        rd_valid_d = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << STEP_BITS;
                mplier_d = mplier_q >> STEP_BITS;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // MADDU wraps modulo 2^(2*WIDTH); the carry out is dropped.
                hilo_d  = maddu_q ? (hilo_q + acc_q) : acc_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over a same-edge commit and leaves Hi/Lo untouched.
        if (flush_w && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            hilo_d  = hilo_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            maddu_q    <= 1'b0;
            hilo_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            maddu_q    <= maddu_d;
            hilo_q     <= hilo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign busy         = (state_q != IDLE);
    assign hi_out       = hilo_q[2*WIDTH-1:WIDTH];
    assign lo_out       = hilo_q[WIDTH-1:0];
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: reset, MULTU/MADDU results and latency, reads, reset abort.
// The abort-input case is compiled only with `define MULDIV_FLUSH_EN.
module tb_muldiv_ctrl;
    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    int          checks = 0;
    int          errors = 0;
    int          n;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32), .STEP_BITS(1)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MULDIV_FLUSH_EN
        .flush  (flush),
`endif
        .bus    (bus.slave),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Present one op, hold until accepted; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("issue_timeout", 64'd1, 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;

        repeat (3) @(negedge clk);
        check("in_reset_ready", 64'(bus.req_ready), 64'd1);
        check("in_reset_busy",  64'(busy),          64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_hi",       64'(hi_out),        64'd0);
        check("rst_lo",       64'(lo_out),        64'd0);
        check("rst_ready",    64'(bus.req_ready), 64'd1);
        check("rst_busy",     64'(busy),          64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid),  64'd0);

        // (2^32-1)^2 = 0xFFFFFFFE_00000001
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        check("multu_busy_cycles", 64'(n),      64'd33);
        check("multu_ff_hi",       64'(hi_out), 64'hFFFF_FFFE);
        check("multu_ff_lo",       64'(lo_out), 64'h0000_0001);
        check("multu_ff_ready",    64'(bus.req_ready), 64'd1);

        // + 0xFFFFFFFF*2 = 0x1_FFFFFFFE -> all ones, then +1*1 wraps to zero
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(n);
        check("maddu_ones_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("maddu_ones_lo", 64'(lo_out), 64'hFFFF_FFFF);
        issue(2'b01, 32'd1, 32'd1);
        wait_idle(n);
        check("maddu_wrap_hi", 64'(hi_out), 64'd0);
        check("maddu_wrap_lo", 64'(lo_out), 64'd0);

        // MULTU 3*5 then MFLO held from E1; operands scrambled after accept
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_op = 2'b11;
        bus.req_a  = 32'hDEAD_BEEF;
        bus.req_b  = 32'h1234_5678;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("mflo_ready_low_cycles", 64'(n), 64'd33);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mflo_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("mflo_rd_data",  64'(bus.rd_data),  64'd15);
        check("mul15_hi",      64'(hi_out),       64'd0);
        @(negedge clk);
        check("mflo_rd_valid_pulse", 64'(bus.rd_valid), 64'd0);

        // back-to-back MFHI then MFLO
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.req_op = 2'b11;
        check("b2b_mfhi_valid", 64'(bus.rd_valid), 64'd1);
        check("b2b_mfhi_data",  64'(bus.rd_data),  64'd0);
        check("b2b_mfhi_busy",  64'(busy),         64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_mflo_valid", 64'(bus.rd_valid), 64'd1);
        check("b2b_mflo_data",  64'(bus.rd_data),  64'd15);
        @(negedge clk);
        check("b2b_valid_drop", 64'(bus.rd_valid), 64'd0);

        // MULTU 7*9 aborted by reset just after E10
        issue(2'b00, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_hi",    64'(hi_out),        64'd0);
        check("abort_lo",    64'(lo_out),        64'd0);
        check("abort_busy",  64'(busy),          64'd0);
        check("abort_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_commit_lo",   64'(lo_out), 64'd0);
        check("abort_no_commit_busy", 64'(busy),   64'd0);

`ifdef MULDIV_FLUSH_EN
        // 2 * 0x80000001 = 0x1_00000002
        issue(2'b00, 32'd2, 32'h8000_0001);
        wait_idle(n);
        check("flush_pre_hi", 64'(hi_out), 64'd1);
        check("flush_pre_lo", 64'(lo_out), 64'd2);
        issue(2'b00, 32'd4, 32'd4);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("flush_hi",         64'(hi_out),        64'd1);
        check("flush_lo",         64'(lo_out),        64'd2);
        check("flush_busy",       64'(busy),          64'd0);
        check("flush_idle_ready", 64'(bus.req_ready), 64'd0);
        flush = 1'b0;
        #1;
        check("flush_release_ready", 64'(bus.req_ready), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
